// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - machine-mode CSR file: EX read port, WB write commit, trap/mret updates, counters
// Optional CSR_WB_BYPASS_EN: same-cycle WB write value is returned on rdata when addresses match.
module csr_regfile #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     raddr,
    output logic [XLEN-1:0] rdata,
    output logic            rillegal,
    input  logic            we,
    input  logic [1:0]      wop,
    input  logic [11:0]     waddr,
    input  logic [XLEN-1:0] wsrc,
    input  logic            retire,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    output logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] mret_target,
    output logic            mstatus_mie
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;

    // MPP is hardwired to machine mode; only MIE/MPIE are stored
    localparam logic [XLEN-1:0] MSTATUS_FIXED = XLEN'(64'h1800);
    localparam logic [XLEN-1:0] LOW2_CLR      = ~XLEN'(3);

    logic            st_mie, st_mpie;
    logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
    logic [XLEN-1:0] mcycle_q, minstret_q;

    logic [XLEN-1:0] mstatus_val, mepc_val;
    logic [XLEN-1:0] cv, nv, rd_val;
    logic            rd_ill, wr_ok;

    always_comb begin
        mstatus_val    = MSTATUS_FIXED;
        mstatus_val[3] = st_mie;
        mstatus_val[7] = st_mpie;
    end

    assign mepc_val = mepc_q & LOW2_CLR;

    // Trap and mret both squash a WB write in the same cycle
    assign wr_ok = we && (wop != 2'b00) && !trap_valid && !mret_valid;

    always_comb begin
        cv = '0;
        case (waddr)
            A_MSTATUS:  cv = mstatus_val;
            A_MIE:      cv = mie_q;
            A_MTVEC:    cv = mtvec_q;
            A_MSCRATCH: cv = mscratch_q;
            A_MEPC:     cv = mepc_val;
            A_MCAUSE:   cv = mcause_q;
            A_MTVAL:    cv = mtval_q;
            A_MIP:      cv = mip_q;
            A_MCYCLE:   cv = mcycle_q;
            A_MINSTRET: cv = minstret_q;
            default:    cv = '0;
        endcase
    end

    always_comb begin
        nv = cv;
        case (wop)
            2'b01:   nv = wsrc;
            2'b10:   nv = cv | wsrc;
            2'b11:   nv = cv & ~wsrc;
            default: nv = cv;
        endcase
    end

`ifdef CSR_WB_BYPASS_EN
    logic [XLEN-1:0] nv_view;
    logic            w_impl;

    always_comb begin
        nv_view = nv;
        w_impl  = 1'b1;
        case (waddr)
            A_MSTATUS: begin
                nv_view    = MSTATUS_FIXED;
                nv_view[3] = nv[3];
                nv_view[7] = nv[7];
            end
            A_MEPC:  nv_view = nv & LOW2_CLR;
            A_MIE, A_MTVEC, A_MSCRATCH, A_MCAUSE, A_MTVAL, A_MIP,
            A_MCYCLE, A_MINSTRET: nv_view = nv;
            default: w_impl = 1'b0;
        endcase
    end
`endif

    always_comb begin
        rd_val = '0;
        rd_ill = 1'b0;
        case (raddr)
            A_MSTATUS:  rd_val = mstatus_val;
            A_MIE:      rd_val = mie_q;
            A_MTVEC:    rd_val = mtvec_q;
            A_MSCRATCH: rd_val = mscratch_q;
            A_MEPC:     rd_val = mepc_val;
            A_MCAUSE:   rd_val = mcause_q;
            A_MTVAL:    rd_val = mtval_q;
            A_MIP:      rd_val = mip_q;
            A_MCYCLE:   rd_val = mcycle_q;
            A_MINSTRET: rd_val = minstret_q;
            default:    rd_ill = 1'b1;
        endcase
`ifdef CSR_WB_BYPASS_EN
        if (wr_ok && w_impl && (waddr == raddr)) begin
            rd_val = nv_view;
        end
`endif
    end

    assign rdata       = rd_val;
    assign rillegal    = rd_ill;
    assign trap_target = mtvec_q & LOW2_CLR;
    assign mret_target = mepc_val;
    assign mstatus_mie = st_mie;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q <= mcycle_q + 1'b1;
            if (retire) begin
                minstret_q <= minstret_q + 1'b1;
            end
            if (trap_valid) begin
                mepc_q   <= trap_pc;
                mcause_q <= trap_cause;
                mtval_q  <= trap_tval;
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end else if (mret_valid) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (wr_ok) begin
                // Counter writes below override the increment scheduled above
                case (waddr)
                    A_MSTATUS: begin
                        st_mie  <= nv[3];
                        st_mpie <= nv[7];
                    end
                    A_MIE:      mie_q      <= nv;
                    A_MTVEC:    mtvec_q    <= nv;
                    A_MSCRATCH: mscratch_q <= nv;
                    A_MEPC:     mepc_q     <= nv;
                    A_MCAUSE:   mcause_q   <= nv;
                    A_MTVAL:    mtval_q    <= nv;
                    A_MIP:      mip_q      <= nv;
                    A_MCYCLE:   mcycle_q   <= nv;
                    A_MINSTRET: minstret_q <= nv;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/csr_regfile.md
# csr_regfile

Machine-mode CSR register file for the 5-stage RV64 pipeline. It holds the architectural CSRs and serves a combinational read port to EX. It commits CSRRW/CSRRS/CSRRC writes from WB and applies trap entry and `mret` state updates. Its read value is the base value that the downstream CSR forwarding selector overrides with in-flight MEM/WB results.

## Interface
Parameters:
- `XLEN`, 64, CSR data width
- `MTVEC_RST`, 64'h0, reset value of `mtvec`

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `raddr`  in  12  CSR read address (EX)
- `rdata`  out  XLEN  read data, combinational
- `rillegal`  out  1  `raddr` not implemented
- `we`  in  1  commit CSR write (WB)
- `wop`  in  2  01 write, 10 set, 11 clear, 00 no-op
- `waddr`  in  12  CSR write address
- `wsrc`  in  XLEN  rs1/zimm operand
- `retire`  in  1  one instruction retires this cycle
- `trap_valid`  in  1  take exception this cycle
- `trap_cause`  in  XLEN  value for `mcause`
- `trap_pc`  in  XLEN  value for `mepc`
- `trap_tval`  in  XLEN  value for `mtval`
- `mret_valid`  in  1  execute `mret` this cycle
- `trap_target`  out  XLEN  `{mtvec[63:2],2'b00}`
- `mret_target`  out  XLEN  current `mepc`
- `mstatus_mie`  out  1  current `mstatus.MIE`

## Operation
- Implemented CSRs and reset values:
  - `mstatus` 0x300: only MIE (bit 3) and MPIE (bit 7) are writable; MPP[12:11] reads 2'b11; reset 64'h1800.
  - `mie` 0x304: reset 0.
  - `mtvec` 0x305: reset `MTVEC_RST`.
  - `mscratch` 0x340, `mepc` 0x341, `mcause` 0x342, `mtval` 0x343, `mip` 0x344: all reset 0.
  - `mcycle` 0xB00, `minstret` 0xB02: both reset 0.
- `mepc` bits [1:0] always read 0.
- Read:
  - `rdata` = selected CSR.
  - An unimplemented address gives `rdata`=0 and `rillegal`=1.
- Write value `nv`, computed from the current value `cv`:
  - `wop`=01: `nv`=`wsrc`.
  - `wop`=10: `nv`=`cv|wsrc`.
  - `wop`=11: `nv`=`cv&~wsrc`.
  - `wop`=00, or `we`=0: no write.
  - A write to an unimplemented or read-only bit or address is silently dropped.
- Trap entry:
  - `mepc`←`trap_pc`, `mcause`←`trap_cause`, `mtval`←`trap_tval`.
  - MPIE←MIE, MIE←0.
- `mret`: MIE←MPIE, MPIE←1.
- Counters:
  - `mcycle` increments by 1 every cycle.
  - `minstret` increments by 1 when `retire`=1.
  - Both wrap modulo 2^64.
- Priority per edge: `rst` > `trap_valid` > `mret_valid` > `we`.
  - A CSR write in the same cycle as a trap or `mret` is discarded.
  - The counters still advance during a trap or `mret`.
- Counter write collision: a write to `mcycle`/`minstret` in the same cycle as its increment takes the written value; the increment is lost for that cycle.
- `trap_valid` and `mret_valid` both high: treat as trap only.

## Timing
- Read path is zero-latency combinational. With the bypass feature off, `rdata` shows the pre-edge value.
- Write, trap and `mret` updates are visible on `rdata` and all outputs starting the cycle after the edge.
- `trap_target` and `mret_target` are combinational from the registered state. The consumer redirects the PC on the same cycle it asserts `trap_valid`/`mret_valid`, using the target value present in that cycle.
- Synchronous reset takes effect at the edge where `rst`=1, even mid-trap. All outputs reflect reset values in the following cycle. `rdata` for `mstatus` then reads 64'h1800.

## Configuration
- `CSR_WB_BYPASS_EN` defined:
  - When `we`=1, `wop`≠00, no trap or `mret` this cycle, and `waddr`==`raddr` (implemented, writable), `rdata` returns the merged `nv` combinationally.
  - This removes the need for the WB-stage CSR forwarding path.
- Undefined: `rdata` always returns stored state. WB forwarding is the external selector's job.

## Test plan
- Reset then read 0x300 -> `rdata`=64'h1800, `mstatus_mie`=0. Read 0x7C0 -> `rdata`=0, `rillegal`=1.
- Three sequential writes to 0x340:
  - CSRRW `wsrc`=64'hF0F0 -> next cycle `rdata`=64'hF0F0.
  - CSRRS 64'h000F -> 64'hF0FF.
  - CSRRC 64'hF000 -> 64'h00FF.
- Trap and return:
  - Set MIE (CSRRS 0x300, 64'h8), then trap with `trap_pc`=64'h1004, cause 64'h2 -> `mepc`=64'h1004, `mcause`=2, MIE=0, MPIE=1.
  - `mret` -> MIE=1, `mret_target`=64'h1004.
- Trap and CSRRW to 0x341 (`wsrc`=64'hDEAD) in the same cycle -> `mepc`=`trap_pc`; the write is dropped.
- Counters:
  - `retire` high for 5 cycles after reset -> `minstret`=5, `mcycle`≥5.
  - Write `mcycle`=64'hFFFF_FFFF_FFFF_FFFF -> wraps to 0 one cycle later.
- Bypass on (`CSR_WB_BYPASS_EN`): `we`=1, CSRRW 0x340=64'h55, with `raddr`=0x340 in the same cycle -> `rdata`=64'h55. Without the macro, `rdata` shows the old value.
